// File: rtl/dino_score_display_if.sv
// dino_score_display_if: control inputs and display outputs of the score display.
interface dino_score_display_if #(
  parameter int DIGITS   = 6,
  parameter int IN_WIDTH = 32
);
  logic                  enable;
  logic [IN_WIDTH-1:0]   score;
  logic                  show_hi;
  logic                  clear_hi;
  logic [4*DIGITS-1:0]   bcd;
  logic [7*DIGITS-1:0]   hex_n;
  logic [IN_WIDTH-1:0]   hi_score;
  logic                  busy;
  logic                  done;
  modport master (output enable, score, show_hi, clear_hi, input bcd, hex_n, hi_score, busy, done);
  modport slave  (input enable, score, show_hi, clear_hi, output bcd, hex_n, hi_score, busy, done);
endinterface

// File: rtl/dino_score_display.sv
// dino_score_display: double-dabble score to BCD and active-low 7-segment converter.
// Define HISCORE_EN to add the session high-score register, show_hi mux and clear_hi.
module dino_score_display #(
  parameter int DIGITS   = 6,
  parameter int IN_WIDTH = 32
) (
  input logic clock,
  input logic reset,
  dino_score_display_if.slave s
);
  localparam int CW = $clog2(IN_WIDTH);
  localparam logic [IN_WIDTH-1:0] MAX = IN_WIDTH'(10**DIGITS - 1);
  localparam logic [7*DIGITS-1:0] HEX_RST = {{(DIGITS-1){7'h7f}}, 7'h40};
  typedef enum logic [1:0] {IDLE, SHIFT, WRITE} state_t;
  state_t state, state_nx;
  logic [IN_WIDTH-1:0] sr, last_src, src, sat, hi;
  logic [4*DIGITS-1:0] acc, adj;
  logic [7*DIGITS-1:0] hex_nx;
  logic [CW-1:0] cnt;
  logic force_f, start, nz;
  function automatic logic [6:0] seg(input logic [3:0] d);
    case (d)
      4'd0: seg = 7'b1000000;
      4'd1: seg = 7'b1111001;
      4'd2: seg = 7'b0100100;
      4'd3: seg = 7'b0110000;
      4'd4: seg = 7'b0011001;
      4'd5: seg = 7'b0010010;
      4'd6: seg = 7'b0000010;
      4'd7: seg = 7'b1111000;
      4'd8: seg = 7'b0000000;
      4'd9: seg = 7'b0010000;
      default: seg = 7'b1111111;
    endcase
  endfunction
`ifdef HISCORE_EN
  always_ff @(posedge clock or posedge reset)
    if (reset) hi <= '0;
    else hi <= s.clear_hi ? '0 : (s.score > hi ? s.score : hi);
  assign src = s.show_hi ? hi : s.score;
`else
  logic unused_hi;
  assign unused_hi = s.show_hi ^ s.clear_hi;
  assign hi  = '0;
  assign src = s.score;
`endif
  assign sat        = src > MAX ? MAX : src;
  assign start      = s.enable && (src != last_src || force_f);
  assign s.busy     = state != IDLE;
  assign s.hi_score = hi;
  always_comb begin
    state_nx = state == IDLE  ? (start ? SHIFT : IDLE) :
               state == SHIFT ? (cnt == CW'(IN_WIDTH-1) ? WRITE : SHIFT) : IDLE;
  end
  always_comb begin
    adj = acc;
    for (int k = 0; k < DIGITS; k++)
      adj[4*k+:4] = acc[4*k+:4] >= 4'd5 ? acc[4*k+:4] + 4'd3 : acc[4*k+:4];
  end
  // scan from the top digit so zeros above the first nonzero digit blank out
  always_comb begin
    hex_nx = '1;
    nz = 1'b0;
    for (int k = DIGITS-1; k >= 0; k--) begin
      nz = nz | (acc[4*k+:4] != 4'd0);
      hex_nx[7*k+:7] = (nz || k == 0) ? seg(acc[4*k+:4]) : 7'h7f;
    end
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      sr       <= '0;
      acc      <= '0;
      cnt      <= '0;
      last_src <= '0;
      force_f  <= 1'b1;
      s.bcd    <= '0;
      s.hex_n  <= HEX_RST;
      s.done   <= 1'b0;
    end else begin
      state  <= state_nx;
      s.done <= state == WRITE;
      if (state == IDLE && start) begin
        sr       <= sat;
        last_src <= src;
        force_f  <= 1'b0;
        acc      <= '0;
        cnt      <= '0;
      end
      if (state == SHIFT) begin
        {acc, sr} <= {adj[4*DIGITS-2:0], sr, 1'b0};
        cnt       <= cnt + 1'b1;
      end
      if (state == WRITE) begin
        s.bcd   <= acc;
        s.hex_n <= hex_nx;
      end
    end
  end
endmodule

// File: tb/tb_dino_score_display.sv
// tb_dino_score_display: scoreboard bench for dino_score_display.
module tb_dino_score_display;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int tests = 0;
  int fails = 0;
  int lat, bsy, act, cur;
  logic [65:0] q[$];
  logic [65:0] e;
  logic [6:0] segs [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
  localparam logic [41:0] HEX_RST = {{5{7'h7f}}, 7'h40};

  dino_score_display_if #(.DIGITS(6), .IN_WIDTH(32)) s();
  dino_score_display #(.DIGITS(6), .IN_WIDTH(32)) dut (.clock(clock), .reset(reset), .s(s));

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [65:0] model(input int unsigned v);
    logic [23:0] b;
    logic [41:0] h;
    logic nz;
    int unsigned x;
    x = v > 999999 ? 999999 : v;
    b = '0;
    for (int k = 0; k < 6; k++) begin
      b[4*k+:4] = 4'(x % 10);
      x = x / 10;
    end
    nz = 1'b0;
    h = '1;
    for (int k = 5; k >= 0; k--) begin
      nz = nz | (b[4*k+:4] != 0);
      if (nz || k == 0) h[7*k+:7] = segs[b[4*k+:4]];
    end
    return {b, h};
  endfunction

  task automatic wait_done(output int l, output int b);
    l = 0;
    b = 0;
    do begin
      @(negedge clock);
      l++;
      if (s.busy) b++;
    end while (!s.done && l < 200);
    if (!s.done) check("timeout", 64'd0, 64'd1);
  endtask

  task automatic idle(input int n, output int a);
    a = 0;
    repeat (n) begin
      @(negedge clock);
      if (s.busy || s.done) a++;
    end
  endtask

  task automatic drive(input int unsigned v);
    s.score = v;
    q.push_back(model(v));
  endtask

  always @(negedge clock)
    if (!reset && s.done) begin
      if (q.size() == 0) check("spurious_done", 64'd1, 64'd0);
      else begin
        e = q.pop_front();
        check("bcd", 64'(e[65:42]), 64'(s.bcd));
        check("hex_n", 64'(e[41:0]), 64'(s.hex_n));
      end
    end

  initial begin
    s.enable = 1'b1;
    s.score = '0;
    s.show_hi = 1'b0;
    s.clear_hi = 1'b0;
    repeat (2) @(negedge clock);
    check("rst_bcd", 64'(s.bcd), 64'd0);
    check("rst_hex", 64'(s.hex_n), 64'(HEX_RST));
    check("rst_busy", 64'(s.busy), 64'd0);
    check("rst_done", 64'(s.done), 64'd0);
    check("rst_hi", 64'(s.hi_score), 64'd0);
    reset = 1'b0;
    q.push_back(model(0));
    wait_done(lat, bsy);
    check("lat_reset", 64'(lat), 64'd34);
    check("busy_reset", 64'(bsy), 64'd33);
    idle(40, act);
    check("no_retrigger", 64'(act), 64'd0);

    drive(1234);
    wait_done(lat, bsy);
    check("lat_1234", 64'(lat), 64'd34);
    check("busy_1234", 64'(bsy), 64'd33);

    drive(999999);
    wait_done(lat, bsy);
    drive(1000000);
    wait_done(lat, bsy);
    drive(5000000);
    wait_done(lat, bsy);
    drive(5000001);
    wait_done(lat, bsy);
    check("lat_sat", 64'(lat), 64'd34);

    drive(10);
    repeat (5) @(negedge clock);
    drive(11);
    wait_done(lat, bsy);
    check("lat_first", 64'(lat), 64'd29);
    wait_done(lat, bsy);
    check("lat_second", 64'(lat), 64'd34);

    s.enable = 1'b0;
    s.score = 7;
    idle(40, act);
    check("blocked_7", 64'(act), 64'd0);
    s.score = 8;
    idle(40, act);
    check("blocked_8", 64'(act), 64'd0);
    s.enable = 1'b1;
    q.push_back(model(8));
    wait_done(lat, bsy);
    check("lat_enable", 64'(lat), 64'd34);

    drive(42);
    repeat (3) @(negedge clock);
    s.enable = 1'b0;
    wait_done(lat, bsy);
    check("lat_no_abort", 64'(lat), 64'd31);
    s.enable = 1'b1;

    cur = 42;
    for (int i = 0; i < 4; i++) begin
      int unsigned v;
      v = $urandom_range(0, 1999999);
      if (v == cur) v++;
      cur = v;
      drive(v);
      wait_done(lat, bsy);
      check("lat_rand", 64'(lat), 64'd34);
    end

    drive(77);
    repeat (5) @(negedge clock);
    reset = 1'b1;
    q.delete();
    s.score = 0;
    @(negedge clock);
    check("mid_rst_bcd", 64'(s.bcd), 64'd0);
    check("mid_rst_hex", 64'(s.hex_n), 64'(HEX_RST));
    check("mid_rst_busy", 64'(s.busy), 64'd0);
    reset = 1'b0;
    q.push_back(model(0));
    wait_done(lat, bsy);
    check("lat_force", 64'(lat), 64'd34);
    check("busy_force", 64'(bsy), 64'd33);

`ifdef HISCORE_EN
    s.clear_hi = 1'b1;
    @(negedge clock);
    check("hi_clear", 64'(s.hi_score), 64'd0);
    s.clear_hi = 1'b0;
    drive(50);
    wait_done(lat, bsy);
    drive(20);
    wait_done(lat, bsy);
    check("hi_50", 64'(s.hi_score), 64'd50);
    s.show_hi = 1'b1;
    q.push_back(model(50));
    wait_done(lat, bsy);
    check("lat_show_hi", 64'(lat), 64'd34);
    s.show_hi = 1'b0;
    q.push_back(model(20));
    wait_done(lat, bsy);
    s.clear_hi = 1'b1;
    drive(30);
    @(negedge clock);
    check("hi_clr_prio", 64'(s.hi_score), 64'd0);
    s.clear_hi = 1'b0;
    @(negedge clock);
    check("hi_after_clr", 64'(s.hi_score), 64'd30);
    wait_done(lat, bsy);
`else
    s.show_hi = 1'b1;
    s.clear_hi = 1'b1;
    idle(40, act);
    check("show_hi_ignored", 64'(act), 64'd0);
    check("hi_tied", 64'(s.hi_score), 64'd0);
    s.show_hi = 1'b0;
    s.clear_hi = 1'b0;
`endif

    repeat (5) @(negedge clock);
    check("queue_empty", 64'(q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
